store_buffer: RTL and testbench

//   In-order store buffer between the CPU memory stage and the 16-bit data memory.
//   - Queues stores so the pipeline does not wait for the memory write port.
//   - Drains queued stores to the data memory one per cycle, in program order.
//   - Serves loads by forwarding from the youngest matching buffered store, or from memory on a miss.
//   - The data memory has one address port with a combinational read and a clocked write.

---
 rtl/store_buffer.sv | 92 +++++++++
 tb/tb_store_buffer.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
// store_buffer: in-order store FIFO draining to a single-port data memory, with youngest-match load forwarding.
// Optional STORE_BUFFER_MERGE_EN: a store to the youngest entry's address overwrites it instead of allocating.
module store_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_st_valid,
  input  logic [ADDR_W-1:0] i_st_addr,
  input  logic [DATA_W-1:0] i_st_data,
  output logic              o_st_ready,
  input  logic              i_ld_valid,
  input  logic [ADDR_W-1:0] i_ld_addr,
  output logic [DATA_W-1:0] o_ld_data,
  output logic              o_ld_fwd,
  output logic              o_sb_empty,
  output logic              o_mem_write_en,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_write_data,
  input  logic [DATA_W-1:0] i_mem_read_data
);
  localparam int PW = $clog2(DEPTH);

  logic [ADDR_W-1:0] r_addr [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];
  logic [DEPTH-1:0]  r_vld;
  logic [PW-1:0]     r_head, r_tail;
  logic [PW:0]       r_count;
  logic [PW-1:0]     w_young;
  logic              w_empty, w_full, w_match, w_acc, w_alloc, w_hit;
  logic [DATA_W-1:0] w_fwd_data;

  assign w_young = r_tail - PW'(1);
  assign w_empty = r_count == '0;
  assign w_full  = r_count == (PW+1)'(DEPTH);

`ifdef STORE_BUFFER_MERGE_EN
  // A draining head cannot absorb a merge: its old data is already on the write port.
  assign w_match = !w_empty && r_addr[w_young] == i_st_addr && !(w_young == r_head && o_mem_write_en);
`else
  assign w_match = 1'b0;
`endif

  assign o_st_ready       = !w_full || w_match;
  assign w_acc            = i_st_valid && o_st_ready;
  assign w_alloc          = w_acc && !w_match;
  assign o_sb_empty       = w_empty;
  assign o_mem_write_en   = !i_ld_valid && !w_empty;
  assign o_mem_addr       = i_ld_valid ? i_ld_addr : r_addr[r_head];
  assign o_mem_write_data = r_data[r_head];
  assign o_ld_fwd         = i_ld_valid && w_hit;
  assign o_ld_data        = w_hit ? w_fwd_data : i_mem_read_data;

  // Scan oldest to youngest so the last hit is the youngest match.
  always_comb begin
    w_hit      = 1'b0;
    w_fwd_data = '0;
    for (int k = 0; k < DEPTH; k++)
      if (r_vld[PW'(r_head + PW'(k))] && r_addr[PW'(r_head + PW'(k))] == i_ld_addr) begin
        w_hit      = 1'b1;
        w_fwd_data = r_data[PW'(r_head + PW'(k))];
      end
  end

  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_vld   <= '0;
    end else begin
      if (w_alloc) begin
        r_vld[r_tail] <= 1'b1;
        r_tail        <= r_tail + PW'(1);
      end
      if (o_mem_write_en) begin
        r_vld[r_head] <= 1'b0;
        r_head        <= r_head + PW'(1);
      end
      r_count <= r_count + (PW+1)'(w_alloc) - (PW+1)'(o_mem_write_en);
    end

  always_ff @(posedge i_clk) begin
    if (w_alloc) begin
      r_addr[r_tail] <= i_st_addr;
      r_data[r_tail] <= i_st_data;
    end
    if (w_acc && w_match) r_data[w_young] <= i_st_data;
  end
endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: directed table, corner sequences and random traffic checked against a queue model of store_buffer.
module tb_store_buffer;
  localparam int DEPTH = 4;

  logic        clk = 1'b0, reset = 1'b1;
  logic        st_valid = 1'b0, ld_valid = 1'b0;
  logic [15:0] st_addr = '0, st_data = '0, ld_addr = '0;
  logic        st_ready, ld_fwd, sb_empty, mem_write_en;
  logic [15:0] ld_data, mem_addr, mem_write_data, mem_read_data;

  logic [15:0] mem     [0:65535];
  logic [15:0] ref_mem [0:65535];

  typedef struct {logic [15:0] a; logic [15:0] d;} ent_t;
  ent_t q[$];

  typedef struct {
    logic sv; logic [15:0] sa; logic [15:0] sd; logic lv; logic [15:0] la;
    logic rdy; logic emp; logic we; logic [15:0] ad; logic [15:0] wd; logic fwd; logic [15:0] ld;
  } vec_t;
  vec_t vt [10];

  int checks = 0, errors = 0;
  logic        m_ready, m_empty, m_we, m_match, m_fwd;
  logic [15:0] m_addr, m_wd, m_ld;

  always #5 clk = ~clk;

  store_buffer #(.DEPTH(DEPTH), .ADDR_W(16), .DATA_W(16)) dut (
    .i_clk(clk), .i_reset(reset),
    .i_st_valid(st_valid), .i_st_addr(st_addr), .i_st_data(st_data), .o_st_ready(st_ready),
    .i_ld_valid(ld_valid), .i_ld_addr(ld_addr), .o_ld_data(ld_data), .o_ld_fwd(ld_fwd),
    .o_sb_empty(sb_empty), .o_mem_write_en(mem_write_en), .o_mem_addr(mem_addr),
    .o_mem_write_data(mem_write_data), .i_mem_read_data(mem_read_data)
  );

  assign mem_read_data = mem[mem_addr];
  always @(posedge clk) if (mem_write_en) mem[mem_addr] <= mem_write_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic model_eval();
    m_empty = q.size() == 0;
    m_we    = !ld_valid && !m_empty;
`ifdef STORE_BUFFER_MERGE_EN
    m_match = q.size() > 0 && q[$].a == st_addr && !(q.size() == 1 && m_we);
`else
    m_match = 1'b0;
`endif
    m_ready = q.size() != DEPTH || m_match;
    m_addr  = ld_valid ? ld_addr : (m_empty ? 16'h0 : q[0].a);
    m_wd    = m_empty ? 16'h0 : q[0].d;
    m_fwd   = 1'b0;
    m_ld    = ref_mem[ld_addr];
    foreach (q[i]) if (q[i].a == ld_addr) begin m_fwd = 1'b1; m_ld = q[i].d; end
  endtask

  task automatic apply(input logic sv, input logic [15:0] sa, input logic [15:0] sd,
                       input logic lv, input logic [15:0] la);
    st_valid = sv; st_addr = sa; st_data = sd; ld_valid = lv; ld_addr = la;
    #2;
    model_eval();
    chk("st_ready", st_ready, m_ready);
    chk("sb_empty", sb_empty, m_empty);
    chk("mem_write_en", mem_write_en, m_we);
    if (m_we || lv) chk("mem_addr", mem_addr, m_addr);
    if (m_we) chk("mem_write_data", mem_write_data, m_wd);
    if (lv) chk("ld_data", ld_data, m_ld);
    chk("ld_fwd", ld_fwd, lv && m_fwd);
  endtask

  task automatic advance();
    if (st_valid && m_ready) begin
      if (m_match) q[$].d = st_data;
      else q.push_back('{st_addr, st_data});
    end
    if (m_we) begin
      ref_mem[q[0].a] = q[0].d;
      void'(q.pop_front());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input logic sv, input logic [15:0] sa, input logic [15:0] sd,
                     input logic lv, input logic [15:0] la);
    apply(sv, sa, sd, lv, la);
    advance();
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) begin mem[i] = '0; ref_mem[i] = '0; end
    vt[0] = '{1'b1, 16'h0003, 16'hBEEF, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000};
    vt[1] = '{1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h0003, 16'hBEEF, 1'b0, 16'h0000};
    vt[2] = '{1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0003, 1'b1, 1'b1, 1'b0, 16'h0003, 16'h0000, 1'b0, 16'hBEEF};
    vt[3] = '{1'b1, 16'h0005, 16'h1111, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000};
    vt[4] = '{1'b1, 16'h0005, 16'h2222, 1'b1, 16'h0005, 1'b1, 1'b0, 1'b0, 16'h0005, 16'h0000, 1'b1, 16'h1111};
    vt[5] = '{1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0005, 1'b1, 1'b0, 1'b0, 16'h0005, 16'h0000, 1'b1, 16'h2222};
    vt[6] = '{1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0009, 1'b1, 1'b0, 1'b0, 16'h0009, 16'h0000, 1'b0, 16'h0000};
`ifdef STORE_BUFFER_MERGE_EN
    vt[7] = '{1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h0005, 16'h2222, 1'b0, 16'h0000};
    vt[8] = '{1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000};
`else
    vt[7] = '{1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h0005, 16'h1111, 1'b0, 16'h0000};
    vt[8] = '{1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h0005, 16'h2222, 1'b0, 16'h0000};
`endif
    vt[9] = '{1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0005, 1'b1, 1'b1, 1'b0, 16'h0005, 16'h0000, 1'b0, 16'h2222};

    #3;
    chk("rst_st_ready", st_ready, 1'b1);
    chk("rst_sb_empty", sb_empty, 1'b1);
    chk("rst_write_en", mem_write_en, 1'b0);
    chk("rst_ld_fwd", ld_fwd, 1'b0);
    @(negedge clk) reset = 1'b0;
    @(posedge clk) #1;

    cyc(1'b1, 16'h0020, 16'h1234, 1'b1, 16'h0099);
    cyc(1'b1, 16'h0021, 16'h5678, 1'b1, 16'h0099);
    st_valid = 1'b0; ld_valid = 1'b0;
    chk("pend_sb_empty", sb_empty, 1'b0);
    #2 reset = 1'b1;
    #1;
    chk("arst_sb_empty", sb_empty, 1'b1);
    chk("arst_st_ready", st_ready, 1'b1);
    chk("arst_write_en", mem_write_en, 1'b0);
    q.delete();
    @(negedge clk) reset = 1'b0;
    @(posedge clk) #1;
    for (int i = 0; i < 3; i++) cyc(1'b0, 16'h0, 16'h0, 1'b0, 16'h0);
    chk("arst_mem20", mem[16'h0020], 16'h0000);
    chk("arst_mem21", mem[16'h0021], 16'h0000);

    for (int i = 0; i < 10; i++) begin
      apply(vt[i].sv, vt[i].sa, vt[i].sd, vt[i].lv, vt[i].la);
      chk($sformatf("vec%0d_ready", i), st_ready, vt[i].rdy);
      chk($sformatf("vec%0d_empty", i), sb_empty, vt[i].emp);
      chk($sformatf("vec%0d_we", i), mem_write_en, vt[i].we);
      if (vt[i].we || vt[i].lv) chk($sformatf("vec%0d_addr", i), mem_addr, vt[i].ad);
      if (vt[i].we) chk($sformatf("vec%0d_wdata", i), mem_write_data, vt[i].wd);
      chk($sformatf("vec%0d_fwd", i), ld_fwd, vt[i].fwd);
      if (vt[i].lv) chk($sformatf("vec%0d_ld", i), ld_data, vt[i].ld);
      advance();
    end
    chk("vec_mem3", mem[16'h0003], 16'hBEEF);
    chk("vec_mem5", mem[16'h0005], 16'h2222);

    for (int i = 0; i < 4; i++) begin
      apply(1'b1, 16'h0010 + 16'(i), 16'hA000 + 16'(i), 1'b1, 16'h00F0);
      chk("fill_ready", st_ready, 1'b1);
      advance();
    end
    for (int i = 0; i < 2; i++) begin
      apply(1'b1, 16'h0014, 16'hA004, 1'b1, 16'h00F0);
      chk("full_ready", st_ready, 1'b0);
      advance();
    end
    for (int i = 0; i < 4; i++) begin
      apply(i < 2, 16'h0014, 16'hA004, 1'b0, 16'h0);
      chk("order_we", mem_write_en, 1'b1);
      chk("order_addr", mem_addr, 16'h0010 + 16'(i));
      chk("order_data", mem_write_data, 16'hA000 + 16'(i));
      advance();
    end
    for (int i = 0; i < 3; i++) cyc(1'b0, 16'h0, 16'h0, 1'b0, 16'h0);
    chk("held_store_mem", mem[16'h0014], 16'hA004);

    for (int i = 0; i < 3; i++) cyc(1'b1, 16'h0030 + 16'(i), 16'hC000 + 16'(i), 1'b1, 16'h00F1);
    for (int i = 0; i < 9; i++) begin
      apply(1'b1, 16'h0040 + 16'(i), 16'hD000 + 16'(i), 1'b0, 16'h0);
      chk("wrap_ready", st_ready, 1'b1);
      chk("wrap_addr", mem_addr, i < 3 ? 16'h0030 + 16'(i) : 16'h0040 + 16'(i - 3));
      advance();
    end
    for (int i = 0; i < 6; i++) cyc(1'b0, 16'h0, 16'h0, 1'b0, 16'h0);
    chk("wrap_mem48", mem[16'h0048], 16'hD008);

    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(0, 99) < 55, 16'($urandom_range(0, 7)), 16'($urandom),
          $urandom_range(0, 99) < 40, 16'($urandom_range(0, 9)));
    for (int i = 0; i < 10 && !sb_empty; i++) cyc(1'b0, 16'h0, 16'h0, 1'b0, 16'h0);
    chk("final_empty", sb_empty, 1'b1);
    for (int i = 0; i < 256; i++) chk($sformatf("final_mem%0d", i), mem[i], ref_mem[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
